// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, widths and line levels
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_baud_counter.sv
// rtl/uart_baud_counter.sv - bit-period counter shared by the UART transmitter and receiver
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] count;

  assign bit_done = (count == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clear || bit_done) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmit serializer: start, 8 data bits LSB-first, optional even parity, stop bits
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1250,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  input  logic       parity_en_i,
  output logic [7:0] parity_data_o,
  output logic       parity_en_o,
  input  logic       parity_bit_i,
  output logic       tx_o,
  output logic       busy_o
);

  tx_state_t  state;
  logic [2:0] bit_idx;
  logic [2:0] bit_nxt;
  logic       bit_done;

  assign bit_nxt    = bit_idx + 3'd1;
  assign tx_ready_o = (state == IDLE);
  assign busy_o     = (state != IDLE);

  // Held clear in IDLE so every slot, including START, starts from count 0.
  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == IDLE),
    .bit_done(bit_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      tx_o          <= UART_IDLE_LVL;
      bit_idx       <= '0;
      parity_data_o <= '0;
      parity_en_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx_o    <= UART_IDLE_LVL;
          bit_idx <= '0;
          if (tx_valid_i) begin
            parity_data_o <= tx_data_i;
            parity_en_o   <= parity_en_i;
            state         <= START;
            tx_o          <= UART_START_LVL;
          end
        end
        START: begin
          if (bit_done) begin
            state   <= DATA;
            tx_o    <= parity_data_o[0];
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
              bit_idx <= '0;
              if (parity_en_o) begin
                state <= PARITY;
                tx_o  <= parity_bit_i;
              end else begin
                state <= STOP;
                tx_o  <= UART_STOP_LVL;
              end
            end else begin
              bit_idx <= bit_nxt;
              tx_o    <= parity_data_o[bit_nxt];
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            state   <= STOP;
            tx_o    <= UART_STOP_LVL;
            bit_idx <= '0;
          end
        end
        STOP: begin
          // bit_idx doubles as the stop-bit counter for two-stop-bit frames.
          if (bit_done) begin
            if (bit_idx == 3'(STOP_BITS - 1)) begin
              state   <= IDLE;
              tx_o    <= UART_IDLE_LVL;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_nxt;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx_o  <= UART_IDLE_LVL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - scoreboard bench for uart_tx_framer with 1 and 2 stop bits
module tb_uart_tx_framer;

  localparam int CPB = 4;

  typedef struct packed {
    logic       sel;
    logic       tx;
    logic       busy;
    logic       ready;
    logic       chk;
    logic [7:0] pd;
    logic       pe;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       parity_en = 1'b0;
  logic       valid_a = 1'b0;
  logic       valid_b = 1'b0;

  logic       ready_a, pen_a, par_a, tx_a, busy_a;
  logic       ready_b, pen_b, par_b, tx_b, busy_b;
  logic [7:0] pdata_a, pdata_b;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  rec_t q[$];

  always #5 clk = ~clk;

  // Parity generators alongside each framer.
  assign par_a = ^pdata_a;
  assign par_b = ^pdata_b;

  uart_tx_framer #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .tx_data_i(tx_data), .tx_valid_i(valid_a), .tx_ready_o(ready_a),
    .parity_en_i(parity_en), .parity_data_o(pdata_a), .parity_en_o(pen_a),
    .parity_bit_i(par_a), .tx_o(tx_a), .busy_o(busy_a)
  );

  uart_tx_framer #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .tx_data_i(tx_data), .tx_valid_i(valid_b), .tx_ready_o(ready_b),
    .parity_en_i(parity_en), .parity_data_o(pdata_b), .parity_en_o(pen_b),
    .parity_bit_i(par_b), .tx_o(tx_b), .busy_o(busy_b)
  );

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin : monitor
    rec_t r;
    cyc++;
    if (q.size() > 0) begin
      r = q.pop_front();
      chk(r.sel ? "b_tx" : "a_tx", {7'd0, r.sel ? tx_b : tx_a}, {7'd0, r.tx});
      chk(r.sel ? "b_busy" : "a_busy", {7'd0, r.sel ? busy_b : busy_a}, {7'd0, r.busy});
      chk(r.sel ? "b_ready" : "a_ready", {7'd0, r.sel ? ready_b : ready_a}, {7'd0, r.ready});
      if (r.chk) begin
        chk(r.sel ? "b_pdata" : "a_pdata", r.sel ? pdata_b : pdata_a, r.pd);
        chk(r.sel ? "b_pen" : "a_pen", {7'd0, r.sel ? pen_b : pen_a}, {7'd0, r.pe});
      end
    end
  end

  task automatic push_rec(input logic sel, input logic tx, input logic busy, input logic ready,
                          input logic c, input logic [7:0] pd, input logic pe);
    rec_t r;
    r = '{sel: sel, tx: tx, busy: busy, ready: ready, chk: c, pd: pd, pe: pe};
    q.push_back(r);
  endtask

  // One idle cycle (the accepting one), then the frame cycle by cycle; maxlen>0 truncates.
  task automatic push_frame(input logic sel, input logic [7:0] data, input logic pen, input logic par,
                            input int stops, input int maxlen);
    int   n;
    int   slots;
    logic lvl;
    n = 0;
    slots = 9 + (pen ? 1 : 0) + stops;
    push_rec(sel, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int s = 0; s < slots; s++) begin
      if (s == 0) lvl = 1'b0;
      else if (s <= 8) lvl = data[s-1];
      else if (pen && s == 9) lvl = par;
      else lvl = 1'b1;
      for (int c = 0; c < CPB; c++) begin
        if (maxlen == 0 || n < maxlen) push_rec(sel, lvl, 1'b1, 1'b0, 1'b1, data, pen);
        n++;
      end
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d records left, want 0", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic sel, input logic [7:0] data, input logic pen, input logic par);
    tx_data   = data;
    parity_en = pen;
    if (sel) valid_b = 1'b1;
    else valid_a = 1'b1;
    push_frame(sel, data, pen, par, sel ? 2 : 1, 0);
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    wait_drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    push_rec(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    push_rec(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    rst = 1'b0;
    wait_drain();

    send(1'b0, 8'h55, 1'b0, 1'b0);
    send(1'b0, 8'h07, 1'b1, 1'b1);
    send(1'b0, 8'h03, 1'b1, 1'b0);

    // Back-to-back with valid held; inputs churn during frame 1.
    tx_data   = 8'hA5;
    parity_en = 1'b0;
    valid_a   = 1'b1;
    push_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1, 0);
    push_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1, 0);
    @(posedge clk);
    #1;
    tx_data   = 8'hFF;
    parity_en = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    tx_data   = 8'h3C;
    parity_en = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    valid_a = 1'b0;
    wait_drain();

    // Reset during bit 3 of 0xF0.
    tx_data   = 8'hF0;
    parity_en = 1'b0;
    valid_a   = 1'b1;
    push_frame(1'b0, 8'hF0, 1'b0, 1'b0, 1, 18);
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    rst = 1'b1;
    push_rec(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_drain();

    send(1'b0, 8'h81, 1'b0, 1'b0);
    send(1'b1, 8'h00, 1'b0, 1'b0);

    push_rec(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    push_rec(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
- Transmit-side UART serializer. Accepts a byte over a valid/ready handshake and emits one frame on the serial line: start bit, 8 data bits LSB-first, optional even-parity bit, then stop bit(s).
- Drives the latched byte and the parity enable to the transmitter parity generator. Consumes that generator's parity bit during the parity slot.
- Sits between the TX byte source (register or FIFO) and the pad.

Parameters:
- CLKS_PER_BIT, 1250: clock cycles per serial bit (12 MHz / 9600 baud). Legal range >= 2.
- STOP_BITS, 1: number of stop bits. Legal values are 1 or 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- tx_data_i  input  8  byte to transmit
- tx_valid_i  input  1  tx_data_i valid
- tx_ready_o  output  1  framer can accept a byte this cycle
- parity_en_i  input  1  include a parity bit in this frame; sampled at accept
- parity_data_o  output  8  latched byte, driven to the parity generator data input
- parity_en_o  output  1  latched parity enable, driven to the parity generator
- parity_bit_i  input  1  even-parity bit returned by the parity generator
- tx_o  output  1  serial line; idles high
- busy_o  output  1  a frame is in progress

Behaviour:
- Reset values: tx_o=1, tx_ready_o=1, busy_o=0, parity_data_o=8'h00, parity_en_o=0. State is IDLE, and the bit counter and baud counter are both 0.
- tx_ready_o = (state==IDLE). Accept occurs when tx_valid_i && tx_ready_o at a rising edge.
- On accept:
  - latch tx_data_i into parity_data_o and parity_en_i into parity_en_o;
  - enter START;
  - tx_o goes 0 on the same edge, so the start bit is visible the cycle after accept.
- tx_o is registered: no combinational path from any input to tx_o.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Every non-IDLE slot holds tx_o for exactly CLKS_PER_BIT cycles. The baud counter runs 0..CLKS_PER_BIT-1 and clears on each slot change.
- START -> DATA: tx_o=parity_data_o[0], bit index=0.
- DATA: at each slot end, bit index++ and tx_o=parity_data_o[index].
  - After bit 7, go to PARITY if parity_en_o=1, otherwise to STOP.
- PARITY: tx_o is loaded from parity_bit_i on the entering edge. parity_bit_i is stable because its inputs are latched.
- STOP: tx_o=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
- The line stays high in IDLE.
- Frame length = (10 + parity_en + STOP_BITS-1) * CLKS_PER_BIT cycles.
- Back-to-back transfers:
  - IDLE is occupied for at least 1 cycle between frames.
  - If tx_valid_i is held high, the next start bit begins 1 cycle after the previous stop slot ends.
- Inputs (tx_data_i, tx_valid_i, parity_en_i) are ignored while busy. parity_data_o and parity_en_o do not change mid-frame.
- busy_o = (state != IDLE).
- Reset mid-frame: next edge forces tx_o=1, IDLE, counters 0 and latches cleared. The partial frame is abandoned and no stop bit is sent.
- Reset has priority over accept in the same cycle.
- Parity is even over the 8 data bits: the parity bit equals the XOR of the data.

Decomposition:
- Package uart_pkg holds:
  - enum tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - UART_DATA_BITS=8;
  - UART_IDLE_LVL=1'b1, UART_START_LVL=1'b0, UART_STOP_LVL=1'b1.
- One natural sub-module: uart_baud_counter, with parameter CLKS_PER_BIT and ports clk, rst, clear, bit_done.
  - bit_done pulses on count==CLKS_PER_BIT-1.
  - clear restarts the count at 0.
  - The module is reused by the receiver.

Test Plan (CLKS_PER_BIT=4, STOP_BITS=1, parity generator instantiated alongside unless noted):
- 0x55, parity_en=0 -> tx_o sequence 0,1,0,1,0,1,0,1,0,1, each held 4 cycles (40 cycles total). tx_ready_o low for those 40 cycles, high after.
- 0x07, parity_en=1 -> data bits 1,1,1,0,0,0,0,0, parity bit 1, stop 1. Frame is 44 cycles; parity_en_o=1 throughout.
- 0x03, parity_en=1 -> parity slot 0. Checks the even-parity sense end to end.
- tx_valid_i held high with 0xA5 then 0x3C -> second start bit begins exactly 1 cycle after the first stop slot ends. Data is LSB-first, and 0x3C is unaffected by changes to tx_data_i during frame 1.
- rst pulsed mid-DATA (bit 3 of 0xF0) -> tx_o=1, busy_o=0, tx_ready_o=1 on the next cycle. A fresh 0x81 then transmits correctly.
- STOP_BITS=2, 0x00, parity off -> 4 cycles low start, 32 cycles low data, 8 cycles high stop (44 cycles), then IDLE.
